// File: rtl/dsp_xintf_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dsp_xintf_responder
// Description : DSP-side responder for the Zynq<->DSP shared DPBRAM link.
//               Terminates the asynchronous DSP XINTF bus. DSP reads are
//               served from the Zynq-to-DSP DPBRAM (port B). DSP writes land
//               in the DSP-to-Zynq DPBRAM (port B). The block also produces
//               the block handshakes for the Zynq-side handler.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option: define XINTF_TIMEOUT_EN to abort strobes held longer than
//               TIMEOUT_CYC clocks in RD_HOLD / WR_WAIT and raise o_bus_err.
//               Without it the FSM waits indefinitely and o_bus_err is 0.
// ----------------------------------------------------------------------------
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_xintf_cs_n/rd_n/we_n   async DSP strobes (active-low)
//   i_xintf_addr/din         DSP word address / write data
//   o_xintf_dout/oe          read data and data-bus output enable
//   o_zd_addr/ce, i_zd_dout  Zynq-to-DSP BRAM read port (1-clock latency)
//   o_dz_addr/din/we         DSP-to-Zynq BRAM write port (we doubles as CE)
//   i_w_valid                Zynq parameter block ready (level)
//   o_w_ready                pulse: DSP consumed the parameter block
//   o_r_valid                pulse: DSP committed the status block
//   o_bus_err                sticky strobe-timeout flag
// Address map: 0-127 read Z2D BRAM, 128-255 write D2Z BRAM,
//              0x1FD write commit, 0x1FE write ack, 0x1FF read status.
// ============================================================================
module dsp_xintf_responder #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_xintf_cs_n,
    input  logic        i_xintf_rd_n,
    input  logic        i_xintf_we_n,
    input  logic [8:0]  i_xintf_addr,
    input  logic [15:0] i_xintf_din,
    output logic [15:0] o_xintf_dout,
    output logic        o_xintf_oe,
    output logic [8:0]  o_zd_addr,
    output logic        o_zd_ce,
    input  logic [15:0] i_zd_dout,
    output logic [8:0]  o_dz_addr,
    output logic [15:0] o_dz_din,
    output logic        o_dz_we,
    input  logic        i_w_valid,
    output logic        o_w_ready,
    output logic        o_r_valid,
    output logic        o_bus_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_ADDR = 3'd1;
    localparam logic [2:0] S_RD_DATA = 3'd2;
    localparam logic [2:0] S_RD_HOLD = 3'd3;
    localparam logic [2:0] S_WR_WAIT = 3'd4;

    localparam logic [8:0] ADDR_COMMIT = 9'h1FD;
    localparam logic [8:0] ADDR_ACK    = 9'h1FE;
    localparam logic [8:0] ADDR_STATUS = 9'h1FF;

    // ------------------------------------------------------------------
    // Strobe synchronizers, edge detectors and address/data capture
    // ------------------------------------------------------------------
    logic        cs_s1_q, cs_s2_q;
    logic        rd_s1_q, rd_s2_q, rd_prev_q, rd_fall_q;
    logic        we_s1_q, we_s2_q, we_prev_q, we_rise_q;
    logic [8:0]  addr_q;
    logic [15:0] din_q;

    // ------------------------------------------------------------------
    // FSM and output registers
    // ------------------------------------------------------------------
    logic [2:0]  state_q,    state_d;
    logic [15:0] dout_q,     dout_d;
    logic        oe_q,       oe_d;
    logic [8:0]  zd_addr_q,  zd_addr_d;
    logic        zd_ce_q,    zd_ce_d;
    logic [8:0]  dz_addr_q,  dz_addr_d;
    logic [15:0] dz_din_q,   dz_din_d;
    logic        dz_we_q,    dz_we_d;
    logic        w_ready_q,  w_ready_d;
    logic        r_valid_q,  r_valid_d;
    logic        ack_pend_q, ack_pend_d;
    logic        ack_wr;
    logic        ack_req;
    logic        w_tmo_hit;

    // ------------------------------------------------------------------
    // Optional strobe timeout
    // ------------------------------------------------------------------
`ifdef XINTF_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             bus_err_q, bus_err_d;
    logic             w_in_wait;

    assign w_in_wait = (state_q == S_RD_HOLD) || (state_q == S_WR_WAIT);
    assign w_tmo_hit = w_in_wait && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC));

    always_comb begin
        tmo_cnt_d = '0;
        if (w_in_wait && !w_tmo_hit) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
        // Sticky until reset.
        bus_err_d = bus_err_q | w_tmo_hit;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmo_cnt_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign o_bus_err = bus_err_q;
`else
    logic w_unused_tmo;

    assign w_tmo_hit    = 1'b0;
    assign o_bus_err    = 1'b0;
    assign w_unused_tmo = (TIMEOUT_CYC > 0);
`endif

    // ------------------------------------------------------------------
    // Ack handshake: an ack write and a pending ack merge into one request,
    // so a repeated ack before i_w_valid rises still yields a single pulse.
    // ------------------------------------------------------------------
    assign ack_req    = ack_wr | ack_pend_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        dout_d     = dout_q;
        oe_d       = oe_q;
        zd_addr_d  = zd_addr_q;
        zd_ce_d    = 1'b0;
        dz_addr_d  = dz_addr_q;
        dz_din_d   = dz_din_q;
        dz_we_d    = 1'b0;
        r_valid_d  = 1'b0;
        ack_wr     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // rd_n and we_n low together is illegal: neither branch fires.
                if (!cs_s2_q && rd_fall_q && !rd_s2_q && we_s2_q) begin
                    state_d   = S_RD_ADDR;
                    zd_addr_d = addr_q;
                    zd_ce_d   = 1'b1;
                end else if (!cs_s2_q && !we_s2_q && rd_s2_q) begin
                    state_d = S_WR_WAIT;
                end
            end

            S_RD_ADDR: begin
                // BRAM samples zd_addr/zd_ce on this edge; data follows next.
                state_d = S_RD_DATA;
            end

            S_RD_DATA: begin
                if (zd_addr_q[8:7] == 2'b00) begin
                    dout_d = i_zd_dout;
                end else if (zd_addr_q == ADDR_STATUS) begin
                    dout_d = {14'b0, ack_pend_q, i_w_valid};
                end else begin
                    dout_d = 16'h0000;
                end
                oe_d    = 1'b1;
                state_d = S_RD_HOLD;
            end

            S_RD_HOLD: begin
                if (w_tmo_hit || rd_s2_q || cs_s2_q) begin
                    oe_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end

            S_WR_WAIT: begin
                if (w_tmo_hit) begin
                    state_d = S_IDLE;
                end else if (we_rise_q) begin
                    state_d = S_IDLE;
                    if (addr_q[8:7] == 2'b01) begin
                        dz_we_d   = 1'b1;
                        dz_addr_d = addr_q;
                        dz_din_d  = din_q;
                    end else if (addr_q == ADDR_COMMIT) begin
                        r_valid_d = 1'b1;
                    end else if (addr_q == ADDR_ACK) begin
                        ack_wr = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                oe_d    = 1'b0;
            end
        endcase

        w_ready_d  = ack_req & i_w_valid;
        ack_pend_d = ack_req & ~i_w_valid;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // Strobes reset to their inactive (high) level so no edge is
            // seen coming out of reset on an idle bus.
            cs_s1_q    <= 1'b1;
            cs_s2_q    <= 1'b1;
            rd_s1_q    <= 1'b1;
            rd_s2_q    <= 1'b1;
            rd_prev_q  <= 1'b1;
            rd_fall_q  <= 1'b0;
            we_s1_q    <= 1'b1;
            we_s2_q    <= 1'b1;
            we_prev_q  <= 1'b1;
            we_rise_q  <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            state_q    <= S_IDLE;
            dout_q     <= '0;
            oe_q       <= 1'b0;
            zd_addr_q  <= '0;
            zd_ce_q    <= 1'b0;
            dz_addr_q  <= '0;
            dz_din_q   <= '0;
            dz_we_q    <= 1'b0;
            w_ready_q  <= 1'b0;
            r_valid_q  <= 1'b0;
            ack_pend_q <= 1'b0;
        end else begin
            cs_s1_q    <= i_xintf_cs_n;
            cs_s2_q    <= cs_s1_q;
            rd_s1_q    <= i_xintf_rd_n;
            rd_s2_q    <= rd_s1_q;
            rd_prev_q  <= rd_s2_q;
            rd_fall_q  <= rd_prev_q & ~rd_s2_q;
            we_s1_q    <= i_xintf_we_n;
            we_s2_q    <= we_s1_q;
            we_prev_q  <= we_s2_q;
            we_rise_q  <= ~we_prev_q & we_s2_q;
            // Bus is sampled only while a synced strobe is low, so the
            // value used downstream has been stable for two clocks.
            if (!cs_s2_q && (!rd_s2_q || !we_s2_q)) begin
                addr_q <= i_xintf_addr;
                din_q  <= i_xintf_din;
            end
            state_q    <= state_d;
            dout_q     <= dout_d;
            oe_q       <= oe_d;
            zd_addr_q  <= zd_addr_d;
            zd_ce_q    <= zd_ce_d;
            dz_addr_q  <= dz_addr_d;
            dz_din_q   <= dz_din_d;
            dz_we_q    <= dz_we_d;
            w_ready_q  <= w_ready_d;
            r_valid_q  <= r_valid_d;
            ack_pend_q <= ack_pend_d;
        end
    end

    assign o_xintf_dout = dout_q;
    assign o_xintf_oe   = oe_q;
    assign o_zd_addr    = zd_addr_q;
    assign o_zd_ce      = zd_ce_q;
    assign o_dz_addr    = dz_addr_q;
    assign o_dz_din     = dz_din_q;
    assign o_dz_we      = dz_we_q;
    assign o_w_ready    = w_ready_q;
    assign o_r_valid    = r_valid_q;

endmodule
`default_nettype wire
